uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive core: 8x oversampled, majority-voted bits, optional parity,
// single-byte holding buffer with acknowledge handshake and overrun flag.
module uart_rx_core #(
  parameter int ACQ_PER_BIT = 8,
  parameter int DATA_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       RxEn_i,
  input  logic       Rx_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       RxAck_i,
  output logic [7:0] RxData_o,
  output logic       RxValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       Overrun_o,
  output logic       Busy_o
);
  localparam int CNT_W = $clog2(ACQ_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACQ_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       smp_q, smp_d;
  logic [7:0]       shf_q, shf_d;
  logic             pen_q, pen_d, pod_q, pod_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             dlv_q, dlv_d;
  logic             rx_s1_q, rx_s2_q;

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d, ovr_q, ovr_d;

  logic             s5, bit_val;

  // The stop bit is decided at count 5, so its third sample is the live line.
  assign s5      = (state_q == STOP) ? rx_s2_q : smp_q[2];
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & s5) | (smp_q[1] & s5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      smp_q   <= '0;
      shf_q   <= '0;
      pen_q   <= 1'b0;
      pod_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dlv_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_s1_q <= Rx_i;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
      pen_q   <= pen_d;
      pod_q   <= pod_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      dlv_q   <= dlv_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    shf_d   = shf_q;
    pen_d   = pen_q;
    pod_d   = pod_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    dlv_d   = 1'b0;
    if (!RxEn_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (AcqSig_i) begin
      if (state_q != IDLE) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(3)) smp_d[0] = rx_s2_q;
        if (cnt_q == CNT_W'(4)) smp_d[1] = rx_s2_q;
        if (cnt_q == CNT_W'(5)) smp_d[2] = rx_s2_q;
      end
      unique case (state_q)
        IDLE: if (!rx_s2_q) begin
          state_d = START;
          cnt_d   = '0;
          pen_d   = ParityEn_i;
          pod_d   = ParityOdd_i;
          perr_d  = 1'b0;
        end
        START: if (cnt_q == CNT_LAST) begin
          state_d = bit_val ? IDLE : DATA;
          idx_d   = '0;
        end
        DATA: if (cnt_q == CNT_LAST) begin
          shf_d = {bit_val, shf_q[7:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = pen_q ? PARITY : STOP;
        end
        PARITY: if (cnt_q == CNT_LAST) begin
          perr_d  = ^shf_q ^ bit_val ^ pod_q;
          state_d = STOP;
        end
        STOP: if (cnt_q == CNT_W'(5)) begin
          ferr_d  = ~bit_val;
          dlv_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding buffer: an ack in the delivery clk frees the slot for the new frame.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    ovr_d   = ovr_q;
    if (valid_q && RxAck_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (dlv_q) begin
      if (!valid_q || RxAck_i) begin
        data_d  = shf_q;
        operr_d = perr_q;
        oferr_d = ferr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign RxData_o    = data_q;
  assign RxValid_o   = valid_q;
  assign ParityErr_o = operr_q;
  assign FrameErr_o  = oferr_q;
  assign Overrun_o   = ovr_q;
  assign Busy_o      = (state_q != IDLE);
endmodule
